// File: rtl/ascon_host_pkg.sv
// Shared types and helpers for the serial Ascon host driver.
// Holds the controller state encoding and sizing helpers.
package ascon_host_pkg;

  localparam int NONCE_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    GAP,
    READ,
    RESP
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ascon_serial_host_if.sv
// Parallel request/response bundle between a client and the Ascon host.
// The slave modport is the host side; the master modport is the client.
interface ascon_serial_host_if
  import ascon_host_pkg::*;
#(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [K-1:0]       cmd_key;
  logic [NONCE_W-1:0] cmd_nonce;
  logic [L-1:0]       cmd_ad;
  logic [Y-1:0]       cmd_pt;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [Y-1:0]       rsp_ct;
  logic [NONCE_W-1:0] rsp_tag;
  logic               rsp_err;

  modport slave (
    input  cmd_valid, cmd_key, cmd_nonce, cmd_ad, cmd_pt,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid, rsp_ct, rsp_tag, rsp_err
  );

  modport master (
    output cmd_valid, cmd_key, cmd_nonce, cmd_ad, cmd_pt,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid, rsp_ct, rsp_tag, rsp_err
  );

endinterface

// File: rtl/ascon_bit_deser.sv
// W-bit LSB-first capture register with enable and clear.
// The first captured bit ends in bit 0 after W enabled cycles.
module ascon_bit_deser #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = {bit_i, data_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/ascon_serial_host.sv
// Host driver for the bit-serial Ascon core: serial load, start pulse,
// wait for ready, then serial capture of ciphertext and tag.
module ascon_serial_host
  import ascon_host_pkg::*;
#(
  parameter int K            = 128,
  parameter int L            = 40,
  parameter int Y            = 40,
  parameter int START_CYCLES = 3,
  parameter int READ_GAP     = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  ascon_serial_host_if.slave        host,
  input  logic [7:0]                rnd,
  output logic [2:0]                keyxSI,
  output logic [2:0]                noncexSI,
  output logic [2:0]                associated_dataxSI,
  output logic [2:0]                plain_textxSI,
  output logic                      encryption_startxSI,
  input  logic                      cipher_textxSO,
  input  logic                      tagxSO,
  input  logic                      encryption_readyxSO
);

  localparam int MAX = max_of(max_of(K, L), Y);
  localparam int CW  =
    $clog2(max_of(MAX, max_of(START_CYCLES, READ_GAP)) + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [K-1:0]       key_q, key_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [L-1:0]       ad_q, ad_d;
  logic [Y-1:0]       pt_q, pt_d;
  logic [2:0]         ksi_q, ksi_d;
  logic [2:0]         nsi_q, nsi_d;
  logic [2:0]         asi_q, asi_d;
  logic [2:0]         psi_q, psi_d;
  logic               start_q, start_d;
  logic               err_q, err_d;
  logic               cap_clr, ct_en, tag_en;
  logic [Y-1:0]       ct_w;
  logic [NONCE_W-1:0] tag_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ad_d    = ad_q;
    pt_d    = pt_q;
    ksi_d   = '0;
    nsi_d   = '0;
    asi_d   = '0;
    psi_d   = '0;
    start_d = 1'b0;
    err_d   = err_q;
    cap_clr = 1'b0;
    ct_en   = 1'b0;
    tag_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host.cmd_valid) begin
          key_d   = host.cmd_key;
          nonce_d = host.cmd_nonce;
          ad_d    = host.cmd_ad;
          pt_d    = host.cmd_pt;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          cap_clr = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Fields shift out MSB-first; zero fill covers short fields.
        ksi_d   = {rnd[7:6], key_q[K-1]};
        asi_d   = {rnd[5:4], ad_q[L-1]};
        psi_d   = {rnd[3:2], pt_q[Y-1]};
        nsi_d   = {rnd[1:0], nonce_q[NONCE_W-1]};
        key_d   = {key_q[K-2:0], 1'b0};
        ad_d    = {ad_q[L-2:0], 1'b0};
        pt_d    = {pt_q[Y-2:0], 1'b0};
        nonce_d = {nonce_q[NONCE_W-2:0], 1'b0};
        if (cnt_q == CW'(MAX - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      START: begin
        start_d = 1'b1;
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (encryption_readyxSO) begin
          cnt_d   = '0;
          state_d = GAP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cap_clr = 1'b1;
          state_d = RESP;
        end
      end
      GAP: begin
        if (cnt_q == CW'(READ_GAP - 1)) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READ: begin
        ct_en  = (cnt_q < CW'(Y));
        tag_en = (cnt_q < CW'(NONCE_W));
        if (cnt_q == CW'(MAX - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (host.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      pt_q    <= '0;
      ksi_q   <= '0;
      nsi_q   <= '0;
      asi_q   <= '0;
      psi_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ad_q    <= ad_d;
      pt_q    <= pt_d;
      ksi_q   <= ksi_d;
      nsi_q   <= nsi_d;
      asi_q   <= asi_d;
      psi_q   <= psi_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  ascon_bit_deser #(.W(Y)) u_ct (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cap_clr),
    .en_i   (ct_en),
    .bit_i  (cipher_textxSO),
    .data_o (ct_w)
  );

  ascon_bit_deser #(.W(NONCE_W)) u_tag (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cap_clr),
    .en_i   (tag_en),
    .bit_i  (tagxSO),
    .data_o (tag_w)
  );

  assign host.cmd_ready      = (state_q == IDLE);
  assign host.rsp_valid      = (state_q == RESP);
  assign host.rsp_err        = err_q;
  assign host.rsp_ct         = ct_w;
  assign host.rsp_tag        = tag_w;
  assign keyxSI              = ksi_q;
  assign noncexSI            = nsi_q;
  assign associated_dataxSI  = asi_q;
  assign plain_textxSI       = psi_q;
  assign encryption_startxSI = start_q;

endmodule

// File: tb/tb_ascon_serial_host.sv
// Directed bench for ascon_serial_host with a small serial core model.
module tb_ascon_serial_host;

  localparam int READ_GAP = 2;
  localparam logic [127:0] KEY   = 128'h2db083053e848cefa30007336c47a5a1;
  localparam logic [127:0] KEY2  = ~128'h2db083053e848cefa30007336c47a5a1;
  localparam logic [127:0] NONCE = 128'h3f3607dbce3503ba84f5843d623de056;
  localparam logic [39:0]  AD    = 40'h4153434f4e;
  localparam logic [39:0]  PT    = 40'h6173636f6e;
  localparam logic [39:0]  CT    = 40'hA1B2C3D4E5;
  localparam logic [127:0] TAG   = 128'h0123456789abcdeffedcba9876543210;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rnd;
  logic [2:0] keyxSI, noncexSI, adxSI, ptxSI;
  logic       startxSI;
  logic       ct_so, tag_so, rdy_so;
  int         cyc = 0;
  int         last_start = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  ascon_serial_host_if #(.K(128), .L(40), .Y(40)) hif ();

  ascon_serial_host #(
    .K(128), .L(40), .Y(40),
    .START_CYCLES(3), .READ_GAP(READ_GAP), .TIMEOUT(100)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .host                (hif),
    .rnd                 (rnd),
    .keyxSI              (keyxSI),
    .noncexSI            (noncexSI),
    .associated_dataxSI  (adxSI),
    .plain_textxSI       (ptxSI),
    .encryption_startxSI (startxSI),
    .cipher_textxSO      (ct_so),
    .tagxSO              (tag_so),
    .encryption_readyxSO (rdy_so)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_chk++;
    if (hif.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_cmd_ready got %b want 1", hif.cmd_ready);
    end
    n_chk++;
    if ({keyxSI, noncexSI, adxSI, ptxSI, startxSI} !== 13'h0) begin
      n_fail++; $display("FAIL rst_xsi got %h want 0",
                         {keyxSI, noncexSI, adxSI, ptxSI, startxSI});
    end
    n_chk++;
    if (hif.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_rsp_valid got %b want 0", hif.rsp_valid);
    end
    n_chk++;
    if (hif.rsp_ct !== 40'h0 || hif.rsp_tag !== 128'h0) begin
      n_fail++; $display("FAIL rst_ct_tag got %h/%h want 0",
                         hif.rsp_ct, hif.rsp_tag);
    end
    n_chk++;
    if (hif.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_err got %b want 0", hif.rsp_err);
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if (hif.cmd_ready !== 1'b1 || startxSI !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_rst got rdy=%b st=%b want 1/0",
                         hif.cmd_ready, startxSI);
    end
  endtask

  task automatic test_load();
    logic [127:0] k_rec, n_rec, a_rec, p_rec;
    logic [7:0]   r;
    int           bad_rnd, bad_misc;
    k_rec = '0; n_rec = '0; a_rec = '0; p_rec = '0;
    bad_rnd = 0; bad_misc = 0;
    hif.cmd_key   = KEY;
    hif.cmd_nonce = NONCE;
    hif.cmd_ad    = AD;
    hif.cmd_pt    = PT;
    hif.cmd_valid = 1'b1;
    tick();
    hif.cmd_valid = 1'b0;
    n_chk++;
    if (hif.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_cmd_ready got %b want 0", hif.cmd_ready);
    end
    for (int i = 0; i < 128; i++) begin
      r = 8'(i * 37 + 5);
      rnd = r;
      tick();
      k_rec = {k_rec[126:0], keyxSI[0]};
      n_rec = {n_rec[126:0], noncexSI[0]};
      a_rec = {a_rec[126:0], adxSI[0]};
      p_rec = {p_rec[126:0], ptxSI[0]};
      if ({keyxSI[2:1], adxSI[2:1], ptxSI[2:1], noncexSI[2:1]} !== r)
        bad_rnd++;
      if (startxSI !== 1'b0 || hif.cmd_ready !== 1'b0) bad_misc++;
    end
    rnd = 8'h00;
    n_chk++;
    if (k_rec !== KEY) begin
      n_fail++; $display("FAIL load_key got %h want %h", k_rec, KEY);
    end
    n_chk++;
    if (n_rec !== NONCE) begin
      n_fail++; $display("FAIL load_nonce got %h want %h", n_rec, NONCE);
    end
    n_chk++;
    if (a_rec !== {AD, 88'h0}) begin
      n_fail++; $display("FAIL load_ad got %h want %h", a_rec, {AD, 88'h0});
    end
    n_chk++;
    if (p_rec !== {PT, 88'h0}) begin
      n_fail++; $display("FAIL load_pt got %h want %h", p_rec, {PT, 88'h0});
    end
    n_chk++;
    if (bad_rnd !== 0) begin
      n_fail++; $display("FAIL load_rnd got %0d bad cycles want 0", bad_rnd);
    end
    n_chk++;
    if (bad_misc !== 0) begin
      n_fail++; $display("FAIL load_misc got %0d bad cycles want 0", bad_misc);
    end
  endtask

  task automatic test_start();
    int highs, first, bad;
    highs = 0; first = -1; bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (startxSI === 1'b1) begin
        highs++;
        last_start = cyc;
        if (first < 0) first = k;
      end
      if ({keyxSI, noncexSI, adxSI, ptxSI} !== 12'h0) bad++;
    end
    n_chk++;
    if (highs !== 3) begin
      n_fail++; $display("FAIL start_len got %0d want 3", highs);
    end
    n_chk++;
    if (first !== 0) begin
      n_fail++; $display("FAIL start_pos got %0d want 0", first);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL start_xsi got %0d nonzero want 0", bad);
    end
  endtask

  task automatic test_timeout();
    int t;
    t = -1;
    for (int k = 0; k < 300 && t < 0; k++) begin
      tick();
      if (hif.rsp_valid === 1'b1) t = cyc;
    end
    n_chk++;
    if (t !== last_start + 100) begin
      n_fail++; $display("FAIL tmo_time got %0d want %0d", t, last_start + 100);
    end
    n_chk++;
    if (hif.rsp_err !== 1'b1) begin
      n_fail++; $display("FAIL tmo_err got %b want 1", hif.rsp_err);
    end
    n_chk++;
    if (hif.rsp_ct !== 40'h0 || hif.rsp_tag !== 128'h0) begin
      n_fail++; $display("FAIL tmo_zero got %h/%h want 0",
                         hif.rsp_ct, hif.rsp_tag);
    end
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
    n_chk++;
    if (hif.rsp_valid !== 1'b0 || hif.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL tmo_release got v=%b r=%b want 0/1",
                         hif.rsp_valid, hif.cmd_ready);
    end
  endtask

  task automatic test_full();
    logic [39:0]  ct_sh;
    logic [127:0] tag_sh;
    logic         found, pre_valid;
    found = 1'b0; pre_valid = 1'bx;
    ct_sh = CT; tag_sh = TAG;
    hif.cmd_valid = 1'b1;
    tick();
    hif.cmd_valid = 1'b0;
    rdy_so = 1'b1;
    for (int k = 0; k < 400 && !found; k++) begin
      tick();
      if (startxSI === 1'b1) found = 1'b1;
    end
    rdy_so = 1'b0;
    n_chk++;
    if (found !== 1'b1) begin
      n_fail++; $display("FAIL full_start got %b want 1", found);
    end
    repeat (50) tick();
    rdy_so = 1'b1;
    tick();
    rdy_so = 1'b0;
    repeat (READ_GAP) tick();
    for (int j = 0; j < 128; j++) begin
      ct_so  = (j < 40) ? ct_sh[0] : 1'b1;
      tag_so = tag_sh[0];
      ct_sh  = ct_sh >> 1;
      tag_sh = tag_sh >> 1;
      if (j == 127) pre_valid = hif.rsp_valid;
      tick();
    end
    ct_so = 1'b0; tag_so = 1'b0;
    n_chk++;
    if (pre_valid !== 1'b0 || hif.rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_valid_time got %b%b want 01",
                         pre_valid, hif.rsp_valid);
    end
    n_chk++;
    if (hif.rsp_ct !== CT) begin
      n_fail++; $display("FAIL full_ct got %h want %h", hif.rsp_ct, CT);
    end
    n_chk++;
    if (hif.rsp_tag !== TAG) begin
      n_fail++; $display("FAIL full_tag got %h want %h", hif.rsp_tag, TAG);
    end
    n_chk++;
    if (hif.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL full_err got %b want 0", hif.rsp_err);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    hif.cmd_key   = KEY2;
    hif.cmd_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (hif.rsp_valid !== 1'b1 || hif.cmd_ready !== 1'b0 ||
          hif.rsp_ct !== CT || hif.rsp_tag !== TAG) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    end
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
    n_chk++;
    if (hif.rsp_valid !== 1'b0 || hif.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got v=%b r=%b want 0/1",
                         hif.rsp_valid, hif.cmd_ready);
    end
    tick();
    hif.cmd_valid = 1'b0;
    n_chk++;
    if (hif.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept got %b want 0", hif.cmd_ready);
    end
    tick();
    n_chk++;
    if (keyxSI[0] !== KEY2[127]) begin
      n_fail++; $display("FAIL b2b_first_bit got %b want %b",
                         keyxSI[0], KEY2[127]);
    end
  endtask

  task automatic test_reset_mid_load();
    int bad;
    bad = 0;
    repeat (59) tick();
    rnd = 8'hFF;
    rst = 1'b0;
    tick();
    n_chk++;
    if ({keyxSI, noncexSI, adxSI, ptxSI, startxSI, hif.rsp_err} !== 14'h0) begin
      n_fail++; $display("FAIL mid_rst_out got %h want 0",
                         {keyxSI, noncexSI, adxSI, ptxSI, startxSI, hif.rsp_err});
    end
    n_chk++;
    if (hif.cmd_ready !== 1'b1 || hif.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_hs got r=%b v=%b want 1/0",
                         hif.cmd_ready, hif.rsp_valid);
    end
    n_chk++;
    if (hif.rsp_ct !== 40'h0 || hif.rsp_tag !== 128'h0) begin
      n_fail++; $display("FAIL mid_rst_data got %h/%h want 0",
                         hif.rsp_ct, hif.rsp_tag);
    end
    rst = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (hif.rsp_valid !== 1'b0 || startxSI !== 1'b0 ||
          hif.cmd_ready !== 1'b1) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL mid_rst_quiet got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    rst           = 1'b0;
    rnd           = 8'h00;
    ct_so         = 1'b0;
    tag_so        = 1'b0;
    rdy_so        = 1'b0;
    hif.cmd_valid = 1'b0;
    hif.cmd_key   = '0;
    hif.cmd_nonce = '0;
    hif.cmd_ad    = '0;
    hif.cmd_pt    = '0;
    hif.rsp_ready = 1'b0;
    test_reset();
    test_load();
    test_start();
    test_timeout();
    test_full();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
